// File: rtl/temporal_lt_array.sv
// temporal_lt_array
// An array of N independent race-logic "a before b" comparators sharing one
// gamma-cycle counter. Race-logic inputs idle at 1 and fall to 0 when their
// event arrives. During a gamma cycle each channel latches its first decision
// (PASS or BLOCK). On the last enabled edge of the gamma cycle (the wrap edge)
// the number of PASS channels is published on pass_cnt, every channel returns
// to IDLE, and gamma_end pulses for one cycle.
module temporal_lt_array #(
    parameter int N        = 8,
    parameter int GAMMA    = 16,
    parameter int TIE_PASS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
    output logic [N-1:0]             c,
    output logic                     gamma_end,
    output logic [$clog2(N+1)-1:0]   pass_cnt
);

    // Counter width never collapses to zero, even for GAMMA == 2.
    localparam int GW = ($clog2(GAMMA) > 1) ? $clog2(GAMMA) : 1;
    localparam int PW = $clog2(N+1);

    localparam logic [GW-1:0] GCNT_LAST = GW'(GAMMA - 1);

    // Per-channel FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_BLOCK = 2'd2;

    logic [GW-1:0] gcnt;
    logic          wrap;
    logic [1:0]    state     [N];
    logic [1:0]    state_nxt [N];
    logic [N-1:0]  c_nxt;
    logic [PW-1:0] pass_now;

    // A wrap edge is an enabled edge taken while the counter sits on its last value.
    assign wrap = en && (gcnt == GCNT_LAST);

    // Decide one channel's next state from its current state and its race inputs.
    function automatic logic [1:0] channel_next(
        input logic [1:0] cur,
        input logic       ai,
        input logic       bi,
        input logic       step,
        input logic       wrap_edge
    );
        logic [1:0] nxt;
        nxt = cur;
        if (step) begin
            if (wrap_edge) begin
                // Inputs sampled on the wrap edge are deliberately ignored.
                nxt = ST_IDLE;
            end else if (cur == ST_IDLE) begin
                case ({ai, bi})
                    2'b01:   nxt = ST_PASS;
                    2'b10:   nxt = ST_BLOCK;
                    2'b00:   nxt = (TIE_PASS != 0) ? ST_PASS : ST_BLOCK;
                    default: nxt = ST_IDLE;
                endcase
            end
        end
        return nxt;
    endfunction

    // Next-state and next-output evaluation for every channel in parallel.
    always_comb begin
        c_nxt = '1;
        for (int i = 0; i < N; i++) begin
            state_nxt[i] = channel_next(state[i], a[i], b[i], en, wrap);
            c_nxt[i]     = (state_nxt[i] != ST_PASS);
        end
    end

    // Count channels currently holding PASS; sampled into pass_cnt on wrap.
    always_comb begin
        pass_now = '0;
        for (int i = 0; i < N; i++) begin
            if (state[i] == ST_PASS) begin
                pass_now = pass_now + PW'(1);
            end
        end
    end

    // Gamma counter: advances on enabled edges, returns to zero on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt <= '0;
        end else if (en) begin
            if (wrap) begin
                gcnt <= '0;
            end else begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

    // Channel state registers; reset discards any partial gamma cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nxt[i];
            end
        end
    end

    // Registered race-logic result: low exactly while the channel is in PASS.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '1;
        end else begin
            c <= c_nxt;
        end
    end

    // Gamma completion pulse and the PASS tally captured before channels clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            gamma_end <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            gamma_end <= wrap;
            if (wrap) begin
                pass_cnt <= pass_now;
            end
        end
    end

endmodule

// File: tb/tb_temporal_lt_array.sv
// Directed bench for temporal_lt_array with N=4, GAMMA=8. Two instances share
// stimulus: u_strict (TIE_PASS=0) and u_tie (TIE_PASS=1).
module tb_temporal_lt_array;

    localparam int N     = 4;
    localparam int GAMMA = 8;
    localparam int PW    = $clog2(N+1);

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [N-1:0]  c0;
    logic [N-1:0]  c1;
    logic          ge0;
    logic          ge1;
    logic [PW-1:0] pc0;
    logic [PW-1:0] pc1;

    int total;
    int bad;

    temporal_lt_array #(.N(N), .GAMMA(GAMMA), .TIE_PASS(0)) u_strict (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .b         (b),
        .c         (c0),
        .gamma_end (ge0),
        .pass_cnt  (pc0)
    );

    temporal_lt_array #(.N(N), .GAMMA(GAMMA), .TIE_PASS(1)) u_tie (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .b         (b),
        .c         (c1),
        .gamma_end (ge1),
        .pass_cnt  (pc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        a     = 4'b1111;
        b     = 4'b1111;
        step();
        step();
        chk("rst_c0",  32'(c0),  32'hF);
        chk("rst_c1",  32'(c1),  32'hF);
        chk("rst_ge0", 32'(ge0), 32'h0);
        chk("rst_pc0", 32'(pc0), 32'h0);
        chk("rst_pc1", 32'(pc1), 32'h0);
        rst = 1'b0;
        en  = 1'b1;

        // Gamma 1: ch0 a-first, ch1 tie, ch2 b-first, ch3 idle.
        step();                           // edge 0
        chk("g1e0_c0", 32'(c0), 32'hF);
        b[2] = 1'b0;
        step();                           // edge 1
        chk("g1e1_c0", 32'(c0), 32'hF);
        a[0] = 1'b0;
        a[2] = 1'b0;
        step();                           // edge 2
        chk("g1e2_c0", 32'(c0), 32'hE);
        chk("g1e2_c1", 32'(c1), 32'hE);
        a[1] = 1'b0;
        b[1] = 1'b0;
        step();                           // edge 3
        chk("g1e3_c0_tie_blocks", 32'(c0), 32'hE);
        chk("g1e3_c1_tie_passes", 32'(c1), 32'hC);
        b[0] = 1'b0;
        step();                           // edge 4
        chk("g1e4_c0_absorb", 32'(c0), 32'hE);
        step();                           // edge 5
        step();                           // edge 6
        chk("g1e6_ge0", 32'(ge0), 32'h0);
        chk("g1e6_c1",  32'(c1),  32'hC);
        step();                           // edge 7 (wrap)
        chk("g1wrap_ge0", 32'(ge0), 32'h1);
        chk("g1wrap_ge1", 32'(ge1), 32'h1);
        chk("g1wrap_pc0", 32'(pc0), 32'h1);
        chk("g1wrap_pc1", 32'(pc1), 32'h2);
        chk("g1wrap_c0",  32'(c0),  32'hF);
        chk("g1wrap_c1",  32'(c1),  32'hF);
        a = 4'b1111;
        b = 4'b1111;

        // Gamma 2: enable stall with a[0] falling inside it.
        step();                           // edge 0
        chk("g2e0_ge0", 32'(ge0), 32'h0);
        chk("g2e0_pc0_hold", 32'(pc0), 32'h1);
        step();                           // edge 1
        en   = 1'b0;
        a[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("g2stall_c0", 32'(c0), 32'hF);
            chk("g2stall_ge0", 32'(ge0), 32'h0);
        end
        en = 1'b1;
        step();                           // edge 2
        chk("g2e2_c0", 32'(c0), 32'hE);
        for (int k = 3; k < 7; k++) begin
            step();                       // edges 3..6
            chk("g2mid_ge0", 32'(ge0), 32'h0);
        end
        chk("g2e6_pc1_hold", 32'(pc1), 32'h2);
        step();                           // edge 7 (wrap)
        chk("g2wrap_ge0", 32'(ge0), 32'h1);
        chk("g2wrap_pc0", 32'(pc0), 32'h1);
        chk("g2wrap_pc1", 32'(pc1), 32'h1);
        chk("g2wrap_c0",  32'(c0),  32'hF);

        // Gamma 3: a[0]=0,b[0]=1 still held -> re-enter PASS, then reset mid-gamma.
        step();                           // edge 0
        chk("g3e0_reenter_c0", 32'(c0), 32'hE);
        chk("g3e0_ge0", 32'(ge0), 32'h0);
        a = 4'b0000;
        b = 4'b1111;
        step();                           // edge 1
        chk("g3e1_allpass_c0", 32'(c0), 32'h0);
        chk("g3e1_allpass_c1", 32'(c1), 32'h0);
        step();                           // edge 2
        step();                           // edge 3
        step();                           // edge 4 -> gcnt = 5
        rst = 1'b1;
        step();
        rst = 1'b0;
        a   = 4'b1111;
        chk("midrst_c0",  32'(c0),  32'hF);
        chk("midrst_c1",  32'(c1),  32'hF);
        chk("midrst_ge0", 32'(ge0), 32'h0);
        chk("midrst_pc0", 32'(pc0), 32'h0);
        chk("midrst_pc1", 32'(pc1), 32'h0);

        // Two idle gammas: gamma_end only after every 8th enabled edge.
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < GAMMA - 1; k++) begin
                step();
                chk("idle_ge0", 32'(ge0), 32'h0);
                chk("idle_c0",  32'(c0),  32'hF);
            end
            step();
            chk("idle_wrap_ge0", 32'(ge0), 32'h1);
            chk("idle_wrap_pc0", 32'(pc0), 32'h0);
            chk("idle_wrap_pc1", 32'(pc1), 32'h0);
        end
        step();
        chk("idle_after_ge1", 32'(ge1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temporal_lt_array.md
TEMPORAL_LT_ARRAY -- requirements
Module: temporal_lt_array

Interface
REQ-001 SHALL have parameter N, default 8: number of independent less-than channels, N >= 1.
REQ-002 SHALL have parameter GAMMA, default 16: enabled cycles per gamma cycle, GAMMA >= 2.
REQ-003 SHALL have parameter TIE_PASS, default 0: 0 = strict a<b, 1 = a<=b (tie passes).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  advance enable; when 0 all state holds.
REQ-007 SHALL have port a  input  N  race-logic input a per channel; 1 = no event yet, 0 = event arrived (held low).
REQ-008 SHALL have port b  input  N  race-logic input b per channel, same encoding as a.
REQ-009 SHALL have port c  output  N  per-channel result, same encoding: 0 = a won.
REQ-010 SHALL have port gamma_end  output  1  one-cycle pulse marking gamma-cycle completion.
REQ-011 SHALL have port pass_cnt  output  $clog2(N+1)  number of channels in PASS at the last gamma end.

Function
REQ-012 SHALL keep a gamma counter gcnt, width max(1,$clog2(GAMMA)), range 0..GAMMA-1; increments by 1 on each posedge with en=1.
REQ-013 At a posedge with en=1 and gcnt==GAMMA-1 (wrap edge), SHALL set gcnt to 0.
REQ-014 SHALL keep a per-channel FSM with states IDLE, PASS, BLOCK.
REQ-015 In IDLE with en=1 on a non-wrap edge: a=0,b=1 -> PASS; a=1,b=0 -> BLOCK; a=0,b=0 -> PASS if TIE_PASS=1, else BLOCK; a=1,b=1 -> stay IDLE.
REQ-016 PASS and BLOCK SHALL be absorbing until the next wrap edge or reset; later input changes SHALL be ignored.
REQ-017 On a wrap edge SHALL return every channel to IDLE; inputs sampled on that edge SHALL NOT cause transitions.
REQ-018 c[i] SHALL be registered; c[i]=0 exactly while channel i is in PASS, else 1.
REQ-019 Latency: c[i] falls on the first posedge where a[i]=0 is sampled with the winning condition true, i.e. one cycle after a[i] falls.
REQ-020 On a wrap edge SHALL load pass_cnt with the count of channels in PASS before clearing; pass_cnt SHALL otherwise hold.
REQ-021 gamma_end SHALL be 1 for exactly the cycle following a wrap edge, else 0.
REQ-022 While en=0: gcnt, FSM states, c, and pass_cnt SHALL hold; gamma_end SHALL be 0 after the next posedge.
REQ-023 After a wrap, inputs are evaluated as presented; a channel whose a stays 0 and b stays 1 SHALL re-enter PASS on the next enabled non-wrap edge. Upstream returns inputs to 1.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on any subset SHALL all take effect on the same edge.

Reset
REQ-025 rst=1 at a posedge SHALL force: all channels IDLE, c={N{1'b1}}, gcnt=0, gamma_end=0, pass_cnt=0.
REQ-026 Reset SHALL take priority over en and over wrap; asserting rst mid-gamma SHALL discard the partial gamma without a gamma_end pulse.

Verification (N=4, GAMMA=8, TIE_PASS=0 unless noted; cycles are enabled edges after reset release)
REQ-027 a[0] falls before edge 2, b[0] before edge 4 -> c[0]=0 from edge 2 until wrap edge 7; gamma_end=1 after edge 7; pass_cnt=1.
REQ-028 a[1] and b[1] fall together before edge 3 -> c[1] stays 1 all gamma. With TIE_PASS=1 -> c[1]=0 from edge 3 and pass_cnt=1.
REQ-029 b[2] falls before edge 1, a[2] before edge 2 -> c[2] stays 1; pass_cnt=0.
REQ-030 All inputs held 1 -> c=4'b1111 throughout; gamma_end pulses after every 8th enabled edge; pass_cnt=0.
REQ-031 en=0 for 3 cycles mid-gamma, a[0] falls during that window -> c[0] holds 1 until the first en=1 edge, then 0; gamma_end delayed by exactly 3 cycles.
REQ-032 All four channels PASS, then rst=1 one cycle at gcnt=5 -> next cycle c=4'b1111, gcnt=0, pass_cnt=0, no gamma_end pulse; the next gamma_end follows 8 enabled edges.
